// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared types and constants for the latch_bank_hold block.
// Provides the controller state encoding and the mode encodings.
package latch_bank_pkg;

    // Controller states of the sample/hold front end.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Values carried on the mode input.
    localparam logic MODE_TRACK = 1'b0;
    localparam logic MODE_SNAP  = 1'b1;

endpackage

// File: rtl/latch_bank_chan.sv
// latch_bank_chan: one WIDTH-bit held word plus its valid flag.
// Ports: clock, clear_n (async low reset), clr (sync clear), load, d_i -> q_i, valid_i.
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_i,
    output logic             valid_i
);

    // clr has priority over load, so a clear on a load edge leaves the
    // channel empty.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q_i     <= '0;
            valid_i <= 1'b0;
        end else if (clr) begin
            q_i     <= '0;
            valid_i <= 1'b0;
        end else if (load) begin
            q_i     <= d_i;
            valid_i <= 1'b1;
        end
    end

endmodule

// File: rtl/latch_bank_hold.sv
// latch_bank_hold: CHANNELS x WIDTH sample/hold bank with TRACK and SNAP modes.
// Ports: clock, clear_n, mode, clr, cap_req, en, d -> q, valid, busy, done.
module latch_bank_hold
    import latch_bank_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      mode,
    input  logic                      clr,
    input  logic                      cap_req,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       valid,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    // Counter value loaded on the capture edge; the hold ends on the
    // edge that sees zero, giving HOLD_CYCLES busy cycles.
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          load_strobe;

    // State, counter and the registered status outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next state and hold counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clr) begin
            state_nx = (mode == MODE_SNAP) ? ST_IDLE : ST_TRACK;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    // mode is not looked at here: a mode change only
                    // lands once the hold has returned to IDLE.
                    if (cnt == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_IDLE, ST_TRACK: begin
                    if (mode == MODE_SNAP && cap_req) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = CNT_LOAD;
                    end else if (mode == MODE_TRACK) begin
                        state_nx = ST_TRACK;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Load strobe for the channels and next values of busy/done.
    always_comb begin
        load_strobe = 1'b0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        if (!clr) begin
            case (state)
                ST_HOLD: begin
                    if (cnt == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        busy_nx = 1'b1;
                    end
                end
                ST_IDLE, ST_TRACK: begin
                    if (mode == MODE_TRACK) begin
                        load_strobe = 1'b1;
                    end else if (cap_req) begin
                        load_strobe = 1'b1;
                        busy_nx     = 1'b1;
                    end
                end
                default: begin
                    load_strobe = 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        latch_bank_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clock  (clock),
            .clear_n(clear_n),
            .clr    (clr),
            .load   (en[i] & load_strobe),
            .d_i    (d[i*WIDTH +: WIDTH]),
            .q_i    (q[i*WIDTH +: WIDTH]),
            .valid_i(valid[i])
        );
    end

endmodule

// File: tb/tb_latch_bank_hold.sv
// tb_latch_bank_hold: self-checking bench for latch_bank_hold.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_latch_bank_hold;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int HC = 3;

    logic          clock;
    logic          clear_n;
    logic          mode;
    logic          clr;
    logic          cap_req;
    logic [CH-1:0] en;
    logic [CH*W-1:0] d;
    logic [CH*W-1:0] q;
    logic [CH-1:0] valid;
    logic          busy;
    logic          done;

    int checks;
    int errors;

    // Behavioural model: words, flags, remaining hold cycles, done flag.
    logic [W-1:0] m_q [CH];
    logic         m_v [CH];
    int           m_left;
    logic         m_done;

    latch_bank_hold #(
        .CHANNELS(CH),
        .WIDTH(W),
        .HOLD_CYCLES(HC)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .mode   (mode),
        .clr    (clr),
        .cap_req(cap_req),
        .en     (en),
        .d      (d),
        .q      (q),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [CH*W-1:0] m_qvec();
        logic [CH*W-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*W +: W] = m_q[i];
        return r;
    endfunction

    function automatic logic [CH-1:0] m_vvec();
        logic [CH-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i] = m_v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_q[i] = '0;
            m_v[i] = 1'b0;
        end
        m_left = 0;
        m_done = 1'b0;
    endtask

    task automatic model_load();
        for (int i = 0; i < CH; i++) begin
            if (en[i]) begin
                m_q[i] = d[i*W +: W];
                m_v[i] = 1'b1;
            end
        end
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_edge();
        if (clr) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else begin
            m_done = 1'b0;
            if (!mode) begin
                model_load();
            end else if (cap_req) begin
                model_load();
                m_left = HC;
            end
        end
    endtask

    task automatic step(input logic m, input logic c, input logic cr,
                        input logic [CH-1:0] e, input logic [CH*W-1:0] dd);
        mode    = m;
        clr     = c;
        cap_req = cr;
        en      = e;
        d       = dd;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        mode = 1'b0; clr = 1'b0; cap_req = 1'b0; en = '0; d = '0;
        model_reset();
        #12;
        clear_n = 1'b1;
        #1;
        checks++;
        if (q !== '0 || valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset q=%h valid=%b busy=%b done=%b want all 0",
                     q, valid, busy, done);
        end
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_track();
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 4'b0101, 32'h44332211);
        checks++;
        if (q !== 32'h00330011 || valid !== 4'b0101) begin
            errors++;
            $display("FAIL track_load q=%h valid=%b want 00330011 0101", q, valid);
        end
        step(1'b0, 1'b0, 1'b1, 4'b0000, 32'hFFEEDDCC);
        checks++;
        if (q !== 32'h00330011 || valid !== 4'b0101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL track_retain q=%h valid=%b busy=%b want 00330011 0101 0",
                     q, valid, busy);
        end
    endtask

    task automatic test_snap();
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'hDDCCBBAA);
        checks++;
        if (q !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL snap_idle q=%h busy=%b want 0 0", q, busy);
        end
        step(1'b1, 1'b0, 1'b1, 4'hF, 32'hDDCCBBAA);
        checks++;
        if (q !== 32'hDDCCBBAA || valid !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL snap_capture q=%h valid=%b busy=%b want DDCCBBAA 1111 1",
                     q, valid, busy);
        end
        for (int k = 0; k < HC - 1; k++) begin
            step(1'b0, 1'b0, 1'b1, 4'hF, 32'h12345678 + k);
            checks++;
            if (q !== 32'hDDCCBBAA || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL snap_hold%0d q=%h busy=%b done=%b want DDCCBBAA 1 0",
                         k, q, busy, done);
            end
        end
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h99999999);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL snap_end busy=%b done=%b q=%h want 0 1 DDCCBBAA",
                     busy, done, q);
        end
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h99999999);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL snap_done_once done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_en_zero();
        step(1'b1, 1'b0, 1'b1, 4'h0, 32'h01020304);
        checks++;
        if (q !== 32'hDDCCBBAA || valid !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL en_zero_capture q=%h valid=%b busy=%b want DDCCBBAA 1111 1",
                     q, valid, busy);
        end
        for (int k = 0; k < HC - 1; k++) step(1'b1, 1'b0, 1'b0, 4'h0, '0);
        step(1'b1, 1'b0, 1'b0, 4'h0, '0);
        checks++;
        if (done !== 1'b1 || q !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL en_zero_done done=%b q=%h want 1 DDCCBBAA", done, q);
        end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b0, 1'b1, 4'hF, 32'h55667788);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0);
        checks++;
        if (busy !== 1'b1 || q !== 32'h55667788) begin
            errors++;
            $display("FAIL abort_setup busy=%b q=%h want 1 55667788", busy, q);
        end
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
        checks++;
        if (q !== '0 || valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear q=%h valid=%b busy=%b done=%b want 0",
                     q, valid, busy, done);
        end
        for (int k = 0; k < HC + 1; k++) begin
            step(1'b1, 1'b0, 1'b0, 4'hF, 32'hAAAAAAAA);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== '0) begin
                errors++;
                $display("FAIL abort_no_done%0d done=%b busy=%b q=%h want 0 0 0",
                         k, done, busy, q);
            end
        end
    endtask

    task automatic test_clr_priority();
        step(1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D);
        checks++;
        if (busy !== 1'b0 || q !== '0 || valid !== '0) begin
            errors++;
            $display("FAIL clr_priority busy=%b q=%h valid=%b want 0 0 0",
                     busy, q, valid);
        end
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'hCAFEF00D);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority_after busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [CH*W-1:0] want_q;
        step(1'b1, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'hF, 32'h10000000 + k);
            want_q = 32'h10000000 + (k - (k % (HC + 1)));
            checks++;
            if (busy !== (k % (HC + 1) != HC) ||
                done !== (k % (HC + 1) == HC) || q !== want_q) begin
                errors++;
                $display("FAIL b2b edge%0d busy=%b done=%b q=%h want %b %b %h",
                         k, busy, done, q, (k % (HC + 1) != HC),
                         (k % (HC + 1) == HC), want_q);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 4'hF, '0);
        step(1'b1, 1'b0, 1'b1, 4'hF, 32'h0BADBEEF);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup busy=%b want 1", busy);
        end
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (q !== '0 || valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate q=%h valid=%b busy=%b done=%b want 0",
                     q, valid, busy, done);
        end
        @(posedge clock);
        #3;
        clear_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0BADBEEF);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== '0) begin
            errors++;
            $display("FAIL areset_release busy=%b done=%b q=%h want 0 0 0",
                     busy, done, q);
        end
    endtask

    task automatic test_random();
        logic c;
        step(1'b0, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 400; k++) begin
            c = ($urandom_range(0, 15) == 0);
            step(1'(($urandom_range(0, 2) != 0)), c, 1'($urandom),
                 4'($urandom), $urandom);
            checks++;
            if (q !== m_qvec() || valid !== m_vvec() ||
                busy !== (m_left > 0) || done !== m_done) begin
                errors++;
                $display("FAIL random%0d q=%h valid=%b busy=%b done=%b want %h %b %b %b",
                         k, q, valid, busy, done, m_qvec(), m_vvec(),
                         (m_left > 0), m_done);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_track();
        test_snap();
        test_en_zero();
        test_abort();
        test_clr_priority();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_bank_hold.md
Name: latch_bank_hold

Overview:
- Parametrised multi-channel successor to the single-bit clearable latch primitive, built as clocked flops rather than a level-sensitive UDP.
- Holds CHANNELS words of WIDTH bits, each with its own load enable.
- Mode input selects TRACK or SNAP:
  - TRACK: enabled channels follow d every cycle.
  - SNAP: one capture per request, then a guaranteed hold window.
- Adds a synchronous clear and per-channel valid flags. Used as a sample/hold front end for downstream datapaths.

Parameters:
- CHANNELS, 4, number of independent channels (>=1)
- WIDTH, 8, bits per channel (>=1)
- HOLD_CYCLES, 3, cycles q is frozen after a SNAP capture (>=1)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- clear_n  in  1  asynchronous active-low reset
- mode  in  1  0 = TRACK, 1 = SNAP
- clr  in  1  synchronous clear of q and valid; aborts a hold
- cap_req  in  1  SNAP capture request, level, sampled each edge
- en  in  CHANNELS  per-channel load enable
- d  in  CHANNELS*WIDTH  channel i data at d[i*WIDTH +: WIDTH]
- q  out  CHANNELS*WIDTH  held data, same packing as d
- valid  out  CHANNELS  channel loaded since last clear/reset
- busy  out  1  high while in HOLD
- done  out  1  one-cycle pulse at end of hold

Behaviour:
- Reset (clear_n=0, asynchronous): q=0, valid=0, busy=0, done=0, state=IDLE, hold counter=0. Release is synchronised by the flop structure only; the first active edge after release evaluates normally.
- Architecture: registered outputs only. busy and done are flops, not decoded combinationally.
- States: IDLE, TRACK, HOLD.
  - IDLE/TRACK, next state: HOLD if mode=1 and cap_req=1 and clr=0; else TRACK if mode=0; else IDLE.
  - IDLE/TRACK loading:
    - In TRACK (mode=0) each edge, channel i with en[i]=1 loads d[i] and sets valid[i]=1. Channels with en[i]=0 retain.
    - cap_req is ignored in mode 0.
    - In IDLE (mode=1, cap_req=0): q retains.
    - On the capture edge (IDLE->HOLD), enabled channels load d and set valid. Disabled channels retain. hold counter := HOLD_CYCLES-1. busy := 1.
  - HOLD:
    - q frozen. en, d, mode and cap_req are all ignored.
    - When counter=0: next state is IDLE, busy := 0, done := 1 for exactly one cycle. Otherwise counter decrements.
    - busy is high for exactly HOLD_CYCLES cycles starting the cycle after the capture edge.
- Priority: clr over everything. On an edge with clr=1: q := 0, valid := 0, done := 0, busy := 0, counter := 0. Next state is IDLE if mode=1, TRACK if mode=0. No done pulse when a hold is aborted.
- Simultaneous events:
  - clr=1 with cap_req=1: clear wins, no capture.
  - cap_req held high across end of hold: the cycle in IDLE with done=1 may re-capture at that edge. Back-to-back captures are therefore spaced HOLD_CYCLES+1 edges apart.
  - en=0 on all channels at capture: hold still runs, done still pulses, q and valid unchanged.
- Mode change while in HOLD takes effect only after return to IDLE.
- Counter width: $clog2(HOLD_CYCLES+1). No wrap; the counter never decrements below 0.
- done is 0 in every cycle except the single post-hold cycle.

Decomposition:
- Package latch_bank_pkg:
  - state enum ST_IDLE, ST_TRACK, ST_HOLD (2-bit)
  - mode constants MODE_TRACK=0, MODE_SNAP=1
- One sub-module: latch_bank_chan, parametrised by WIDTH, instanced CHANNELS times via generate.
  - Inputs: clock, clear_n, clr, load (= en[i] & load_strobe from the controller), d_i.
  - Outputs: q_i, valid_i.
- Controller FSM and hold counter stay in the top module.

Test Plan (CHANNELS=4, WIDTH=8, HOLD_CYCLES=3):
- Reset mid-operation: reach HOLD with busy=1, pulse clear_n=0 between edges -> q=0, valid=0, busy=0, done=0 immediately, without waiting for a clock edge.
- TRACK: mode=0, en=4'b0101, d=0x44_33_22_11 -> after one edge q=0x00_33_00_11, valid=4'b0101. Then en=0, d changes -> q unchanged.
- SNAP:
  - Setup: mode=1, en=4'b1111, d=0xDD_CC_BB_AA, 1-cycle cap_req.
  - Capture: q=0xDD_CC_BB_AA, busy=1 for 3 cycles.
  - During hold: d changes and cap_req=1 -> q unchanged.
  - End of hold: done=1 for exactly 1 cycle after busy falls.
- Abort: clr=1 on the second busy cycle -> q=0, valid=0, busy=0, state IDLE, no done pulse.
- Priority and back-to-back:
  - clr=1 together with cap_req=1 -> no capture, busy stays 0.
  - cap_req held high -> capture edges every 4 cycles, done pulses every 4 cycles.
